// File: rtl/pea_result_reader.sv
// Drains paired result/status words from the PEA output FIFOs onto a host valid/ready stream.
// Optional build macro PEA_READER_STATUS_FILTER_EN drops pairs with nonzero status instead of forwarding them.
module pea_result_reader #(
    parameter int width     = 32,
    parameter int pop_width = 1,
    parameter int cnt_width = 16,
    parameter int timeout   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clr,
    input  logic [pop_width-1:0] result_pop,
    input  logic [pop_width-1:0] status_pop,
    input  logic [width-1:0]     result_data,
    input  logic [width-1:0]     status_data,
    output logic                 rd_en_result,
    output logic                 rd_en_status,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_result,
    output logic [width-1:0]     out_status,
    output logic                 busy,
    output logic                 desync,
    output logic [cnt_width-1:0] txn_count,
    output logic [cnt_width-1:0] err_count
);

    localparam int SKEW_W = $clog2(timeout + 1);
    localparam logic [SKEW_W-1:0]    SKEW_MAX  = SKEW_W'(timeout);
    localparam logic [SKEW_W-1:0]    SKEW_LAST = SKEW_W'(timeout - 1);
    localparam logic [SKEW_W-1:0]    SKEW_ONE  = SKEW_W'(1);
    localparam logic [cnt_width-1:0] CNT_ONE   = cnt_width'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   rd_en_q, rd_en_d;
    logic                   out_valid_q, out_valid_d;
    logic [width-1:0]       out_result_q, out_result_d;
    logic [width-1:0]       out_status_q, out_status_d;
    logic                   busy_q, busy_d;
    logic                   desync_q, desync_d;
    logic [cnt_width-1:0]   txn_q, txn_d;
    logic [cnt_width-1:0]   err_q, err_d;
    logic [SKEW_W-1:0]      skew_q, skew_d;

    logic result_nz;
    logic status_nz;
    logic status_err;

    assign result_nz  = (result_pop != '0);
    assign status_nz  = (status_pop != '0);
    assign status_err = (status_data != '0);

    always_comb begin
        state_d      = state_q;
        rd_en_d      = 1'b0;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_status_d = out_status_q;
        desync_d     = desync_q;
        txn_d        = txn_q;
        err_d        = err_q;
        skew_d       = skew_q;

        case (state_q)
            IDLE: begin
                // Skew only tracks while idle; during a transaction the populations legitimately move.
                if (result_nz ^ status_nz) begin
                    if (skew_q >= SKEW_LAST) begin
                        skew_d   = SKEW_MAX;
                        desync_d = 1'b1;
                    end else begin
                        skew_d = skew_q + SKEW_ONE;
                    end
                end else begin
                    skew_d = '0;
                end
                if (enable && result_nz && status_nz && !desync_q) begin
                    state_d = POP;
                    rd_en_d = 1'b1;
                end
            end
            POP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                out_result_d = result_data;
                out_status_d = status_data;
                if (txn_q != '1) begin
                    txn_d = txn_q + CNT_ONE;
                end
                if (status_err && (err_q != '1)) begin
                    err_d = err_q + CNT_ONE;
                end
`ifdef PEA_READER_STATUS_FILTER_EN
                if (status_err) begin
                    state_d = IDLE;
                end else begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                end
`else
                state_d     = SEND;
                out_valid_d = 1'b1;
`endif
            end
            SEND: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Clear overrides any same-cycle counter increment or desync detection.
        if (clr) begin
            txn_d    = '0;
            err_d    = '0;
            desync_d = 1'b0;
            skew_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_status_q <= '0;
            busy_q       <= 1'b0;
            desync_q     <= 1'b0;
            txn_q        <= '0;
            err_q        <= '0;
            skew_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_status_q <= out_status_d;
            busy_q       <= busy_d;
            desync_q     <= desync_d;
            txn_q        <= txn_d;
            err_q        <= err_d;
            skew_q       <= skew_d;
        end
    end

    assign rd_en_result = rd_en_q;
    assign rd_en_status = rd_en_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_status   = out_status_q;
    assign busy         = busy_q;
    assign desync       = desync_q;
    assign txn_count    = txn_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_pea_result_reader.sv
// Directed bench for pea_result_reader: a small FIFO model drives populations and read data.
module tb_pea_result_reader;

    localparam int W  = 32;
    localparam int PW = 2;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] result_pop = '0;
    logic [PW-1:0] status_pop = '0;
    logic [W-1:0]  result_data = 32'hDEADBEEF;
    logic [W-1:0]  status_data = 32'hDEADBEEF;
    logic          rd_en_result, rd_en_status, out_valid, busy, desync;
    logic [W-1:0]  out_result, out_status;
    logic [CW-1:0] txn_count, err_count;

    int total = 0;
    int bad = 0;
    int res_cnt = 0;
    int sta_cnt = 0;
    int rd_pulses = 0;
    logic [W-1:0] res_word = '0;
    logic [W-1:0] sta_word = '0;

    always #5 clk = ~clk;

    pea_result_reader #(
        .width(W), .pop_width(PW), .cnt_width(CW), .timeout(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .result_pop(result_pop), .status_pop(status_pop),
        .result_data(result_data), .status_data(status_data),
        .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status),
        .busy(busy), .desync(desync),
        .txn_count(txn_count), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_pops();
        result_pop = (res_cnt >= 3) ? PW'(3) : PW'(res_cnt);
        status_pop = (sta_cnt >= 3) ? PW'(3) : PW'(sta_cnt);
    endtask

    task automatic set_fifo(input int r, input int s);
        res_cnt = r;
        sta_cnt = s;
        update_pops();
    endtask

    // One clock: FIFO model returns popped words the cycle after the strobe.
    task automatic tick();
        logic rr, rs;
        rr = rd_en_result;
        rs = rd_en_status;
        if (out_valid && out_ready)
            $display("txn result=%08h status=%08h txn_count=%0d err_count=%0d",
                     out_result, out_status, txn_count, err_count);
        @(posedge clk);
        #1;
        if (rr != rs) check("strobe_pair", rs, rr);
        if (rr) begin
            check("underflow_result", res_cnt > 0, 1);
            if (res_cnt > 0) res_cnt--;
            rd_pulses++;
        end
        if (rs) begin
            check("underflow_status", sta_cnt > 0, 1);
            if (sta_cnt > 0) sta_cnt--;
        end
        result_data = rr ? res_word : 32'hDEADBEEF;
        status_data = rs ? sta_word : 32'hDEADBEEF;
        update_pops();
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) tick();
        check("valid_wait", out_valid, 1);
    endtask

    initial begin
        int p;
        logic [W-1:0] held;
        logic seen_valid;

        // Power-on reset
        #3 rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en_result, 0);
        check("rst_txn", txn_count, 0);
        check("rst_desync", desync, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset while presenting a pair
        res_word = 32'h0000002A;
        sta_word = 32'h00000000;
        set_fifo(1, 1);
        enable = 1'b1;
        out_ready = 1'b0;
        wait_valid(8);
        enable = 1'b0;
        check("pre_rst_result", out_result, 32'h2A);
        check("pre_rst_txn", txn_count, 1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_txn", txn_count, 0);
        check("async_rst_result", out_result, 0);
        check("async_rst_busy", busy, 0);
        #1 rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_valid, 0);

        // Single pair with exact latency
        res_word = 32'h0000002A;
        sta_word = 32'h00000000;
        out_ready = 1'b1;
        set_fifo(1, 1);
        enable = 1'b1;
        tick();
        check("lat_rd_en_t1", rd_en_result, 1);
        check("lat_rd_en_s_t1", rd_en_status, 1);
        enable = 1'b0;
        tick();
        check("lat_rd_en_t2", rd_en_result, 0);
        check("lat_valid_t2", out_valid, 0);
        tick();
        check("lat_valid_t3", out_valid, 1);
        check("single_result", out_result, 32'd42);
        check("single_status", out_status, 0);
        check("single_txn", txn_count, 1);
        check("single_err", err_count, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_done_valid", out_valid, 0);
        check("single_done_busy", busy, 0);

        // Backpressure
        res_word = 32'h12345678;
        sta_word = 32'h0;
        out_ready = 1'b0;
        set_fifo(1, 1);
        enable = 1'b1;
        wait_valid(8);
        enable = 1'b0;
        set_fifo(1, 1);
        held = out_result;
        p = rd_pulses;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_stable", out_result, held);
        end
        check("bp_result", held, 32'h12345678);
        check("bp_no_pop", rd_pulses, p);
        out_ready = 1'b1;
        tick();
        check("bp_accept_valid", out_valid, 0);
        check("bp_accept_busy", busy, 0);
        check("bp_txn", txn_count, 2);
        set_fifo(0, 0);
        tick();

        // Error status
        res_word = 32'h00000007;
        sta_word = 32'h00000003;
        set_fifo(1, 1);
        enable = 1'b1;
        p = rd_pulses;
`ifdef PEA_READER_STATUS_FILTER_EN
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        enable = 1'b0;
        check("filter_no_valid", seen_valid, 0);
`else
        wait_valid(8);
        enable = 1'b0;
        check("err_status_fwd", out_status, 32'h3);
        check("err_result_fwd", out_result, 32'h7);
`endif
        check("err_pop_once", rd_pulses, p + 1);
        check("err_txn", txn_count, 3);
        check("err_err", err_count, 1);
        tick();
        tick();

        // Desync detection and clear
        res_word = 32'hA5A50001;
        sta_word = 32'h0;
        set_fifo(1, 0);
        enable = 1'b1;
        p = rd_pulses;
        for (int i = 0; i < TO - 1; i++) tick();
        check("desync_early", desync, 0);
        tick();
        check("desync_set", desync, 1);
        check("desync_no_pop", rd_pulses, p);
        set_fifo(1, 1);
        for (int i = 0; i < 5; i++) tick();
        check("desync_sticky", desync, 1);
        check("desync_blocks_pop", rd_pulses, p);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_desync", desync, 0);
        check("clr_txn", txn_count, 0);
        check("clr_err", err_count, 0);
        wait_valid(8);
        enable = 1'b0;
        check("desync_pop", rd_pulses, p + 1);
        check("desync_result", out_result, 32'hA5A50001);
        check("desync_txn", txn_count, 1);
        tick();
        tick();

        // Counter saturation with error pairs
        clr = 1'b1;
        tick();
        clr = 1'b0;
        res_word = 32'h00000009;
        sta_word = 32'h00000005;
        out_ready = 1'b1;
        set_fifo(100, 100);
        enable = 1'b1;
        p = rd_pulses;
        for (int i = 0; i < 200 && (rd_pulses - p) < 17; i++) tick();
        enable = 1'b0;
        check("sat_pulses", rd_pulses - p, 17);
        for (int i = 0; i < 8; i++) tick();
        check("sat_txn", txn_count, 15);
        check("sat_err", err_count, 15);
        check("enable_low_no_pop", rd_pulses - p, 17);
        check("enable_low_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
